// File: rtl/cnn1d_infer_ctrl_if.sv
// rtl/cnn1d_infer_ctrl_if.sv - handshake bundle for the 1D CNN inference frame sequencer
//
// Groups every non-clock/reset signal of cnn1d_infer_ctrl.
//   master : environment side (sample source, conv input, neuron layer, decision consumer)
//   slave  : the sequencer itself
// Signals:
//   start / busy                              inference trigger and activity flag
//   src_valid / src_ready / src_data          raw sample stream in
//   cnn_valid_in / cnn_ready_in / cnn_data_in gated sample stream to the conv layer
//   res_valid / res_ready / res_data0/1       neuron layer scores (NEW, WORN)
//   out_valid / out_ready / out_condition / out_timeout / out_frame_id   tagged decision
interface cnn1d_infer_ctrl_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int FRAME_ID_WIDTH = 8
);
   logic                      start;
   logic                      busy;
   logic                      src_valid;
   logic                      src_ready;
   logic [DATA_WIDTH-1:0]     src_data;
   logic                      cnn_valid_in;
   logic                      cnn_ready_in;
   logic [DATA_WIDTH-1:0]     cnn_data_in;
   logic                      res_valid;
   logic                      res_ready;
   logic [DATA_WIDTH-1:0]     res_data0;
   logic [DATA_WIDTH-1:0]     res_data1;
   logic                      out_valid;
   logic                      out_ready;
   logic                      out_condition;
   logic                      out_timeout;
   logic [FRAME_ID_WIDTH-1:0] out_frame_id;

   modport master (
      output start, src_valid, src_data, cnn_ready_in, res_valid, res_data0, res_data1, out_ready,
      input  busy, src_ready, cnn_valid_in, cnn_data_in, res_ready, out_valid, out_condition,
             out_timeout, out_frame_id
   );

   modport slave (
      input  start, src_valid, src_data, cnn_ready_in, res_valid, res_data0, res_data1, out_ready,
      output busy, src_ready, cnn_valid_in, cnn_data_in, res_ready, out_valid, out_condition,
             out_timeout, out_frame_id
   );
endinterface

// File: rtl/cnn1d_infer_ctrl.sv
// rtl/cnn1d_infer_ctrl.sv - frame-level sequencer for the 1D CNN inference datapath
//
// Gates FRAME_LEN samples from the source into the conv layer per inference, waits for the
// two neuron-layer scores, and reports a tagged NEW(0)/WORN(1) decision. A watchdog aborts
// the wait after TIMEOUT_CYCLES cycles and reports a timeout decision instead.
//
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset
//   bus  : cnn1d_infer_ctrl_if.slave (start/busy, src_*, cnn_*, res_*, out_*)
//
// Build option:
//   CNN1D_INFER_CTRL_AUTORESTART_EN : after an accepted normal report, re-enter FEED
//   without a new start; a timeout report still returns to IDLE.
module cnn1d_infer_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int FRAME_LEN      = 256,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int FRAME_ID_WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   cnn1d_infer_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FEED   = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_REPORT = 2'd3;

   // +1 keeps the widths non-zero when FRAME_LEN or TIMEOUT_CYCLES is 1
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]                state_q;
   logic [CNT_W-1:0]          sample_cnt_q;
   logic [TO_W-1:0]           timeout_cnt_q;
   logic [FRAME_ID_WIDTH-1:0] frame_id_q;
   logic                      condition_q;
   logic                      timeout_q;

   logic signed [DATA_WIDTH-1:0] score_new;
   logic signed [DATA_WIDTH-1:0] score_worn;
   logic                         in_feed;
   logic                         sample_hs;

   assign score_new  = bus.res_data0;
   assign score_worn = bus.res_data1;
   assign in_feed    = (state_q == S_FEED);
   // Counted on the source/conv pair directly so the count matches what the conv layer took
   assign sample_hs  = in_feed & bus.src_valid & bus.cnn_ready_in;

   // Zero-latency pass-through while feeding; data is never gated, only the handshake is
   assign bus.cnn_data_in   = bus.src_data;
   assign bus.cnn_valid_in  = in_feed & bus.src_valid;
   assign bus.src_ready     = in_feed & bus.cnn_ready_in;
   assign bus.res_ready     = (state_q == S_WAIT);
   assign bus.out_valid     = (state_q == S_REPORT);
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.out_condition = condition_q;
   assign bus.out_timeout   = timeout_q;
   assign bus.out_frame_id  = frame_id_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         sample_cnt_q  <= '0;
         timeout_cnt_q <= '0;
         frame_id_q    <= '0;
         condition_q   <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q      <= S_FEED;
                  sample_cnt_q <= '0;
               end
            end
            S_FEED: begin
               if (sample_hs) begin
                  if (sample_cnt_q == CNT_LAST) begin
                     state_q       <= S_WAIT;
                     timeout_cnt_q <= '0;
                  end else begin
                     sample_cnt_q <= sample_cnt_q + 1'b1;
                  end
               end
            end
            S_WAIT: begin
               // A result arriving on the expiry cycle takes priority over the watchdog
               if (bus.res_valid) begin
                  condition_q <= (score_new < score_worn);
                  timeout_q   <= 1'b0;
                  state_q     <= S_REPORT;
               end else if (timeout_cnt_q == TO_LAST) begin
                  condition_q <= 1'b0;
                  timeout_q   <= 1'b1;
                  state_q     <= S_REPORT;
               end else begin
                  timeout_cnt_q <= timeout_cnt_q + 1'b1;
               end
            end
            S_REPORT: begin
               if (bus.out_ready) begin
                  frame_id_q <= frame_id_q + 1'b1;
`ifdef CNN1D_INFER_CTRL_AUTORESTART_EN
                  if (timeout_q) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q      <= S_FEED;
                     sample_cnt_q <= '0;
                  end
`else
                  state_q <= S_IDLE;
`endif
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cnn1d_infer_ctrl.sv
// tb/tb_cnn1d_infer_ctrl.sv - directed self-checking bench for cnn1d_infer_ctrl
module tb_cnn1d_infer_ctrl;

   localparam int DW  = 32;
   localparam int FL  = 4;
   localparam int TO  = 8;
   localparam int FIW = 8;
`ifdef CNN1D_INFER_CTRL_AUTORESTART_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [FIW-1:0] exp_fid = '0;
   bit   expect_idle = 1'b1;

   cnn1d_infer_ctrl_if #(.DATA_WIDTH(DW), .FRAME_ID_WIDTH(FIW)) bus ();

   cnn1d_infer_ctrl #(
      .DATA_WIDTH(DW), .FRAME_LEN(FL), .TIMEOUT_CYCLES(TO), .FRAME_ID_WIDTH(FIW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time limit reached");
      $fatal(1);
   end

   // Feeds n samples; starts at a negedge, ends at the negedge after the last handshake.
   task automatic feed(input int n, input int pattern, input bit poke_start, output int cycles);
      int hs;
      hs = 0;
      cycles = 0;
      if (expect_idle) begin
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      while (hs < n && cycles < 40) begin
         bus.src_valid    = (pattern == 0) ? 1'b1 : ((cycles % 3) != 2);
         bus.cnn_ready_in = (pattern == 0) ? 1'b1 : ((cycles % 2) == 0);
         bus.src_data     = 32'hA000_0000 + 32'(cycles);
         bus.start        = poke_start && (cycles == 1);
         #1;
         checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL feed_busy: got %b want 1", bus.busy); end
         checks++; if (bus.src_ready !== bus.cnn_ready_in) begin errors++; $display("FAIL feed_src_ready: got %b want %b", bus.src_ready, bus.cnn_ready_in); end
         checks++; if (bus.cnn_valid_in !== bus.src_valid) begin errors++; $display("FAIL feed_cnn_valid: got %b want %b", bus.cnn_valid_in, bus.src_valid); end
         checks++; if (bus.cnn_data_in !== 32'hA000_0000 + 32'(cycles)) begin errors++; $display("FAIL feed_data: got %h want %h", bus.cnn_data_in, 32'hA000_0000 + 32'(cycles)); end
         checks++; if (bus.res_ready !== 1'b0) begin errors++; $display("FAIL feed_res_ready: got %b want 0", bus.res_ready); end
         if (bus.cnn_valid_in && bus.cnn_ready_in) hs++;
         cycles++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      checks++; if (hs !== n) begin errors++; $display("FAIL feed_handshakes: got %0d want %0d", hs, n); end
      if (n == FL) begin
         bus.src_valid    = 1'b1;
         bus.cnn_ready_in = 1'b1;
         #1;
         checks++; if (bus.src_ready !== 1'b0 || bus.cnn_valid_in !== 1'b0) begin errors++; $display("FAIL wait_gate: src_ready=%b cnn_valid_in=%b want 0 0", bus.src_ready, bus.cnn_valid_in); end
         checks++; if (bus.res_ready !== 1'b1) begin errors++; $display("FAIL wait_res_ready: got %b want 1", bus.res_ready); end
      end
      bus.src_valid    = 1'b0;
      bus.cnn_ready_in = 1'b0;
   endtask

   task automatic give_result(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic exp_cond);
      bus.res_valid = 1'b1;
      bus.res_data0 = d0;
      bus.res_data1 = d1;
      @(negedge clk);
      bus.res_valid = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL report_valid: got %b want 1", bus.out_valid); end
      checks++; if (bus.out_condition !== exp_cond) begin errors++; $display("FAIL report_condition: got %b want %b", bus.out_condition, exp_cond); end
      checks++; if (bus.out_timeout !== 1'b0) begin errors++; $display("FAIL report_timeout: got %b want 0", bus.out_timeout); end
      checks++; if (bus.out_frame_id !== exp_fid) begin errors++; $display("FAIL report_frame_id: got %0d want %0d", bus.out_frame_id, exp_fid); end
   endtask

   task automatic accept(input bit was_timeout);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      exp_fid     = exp_fid + 1'b1;
      expect_idle = was_timeout || !AUTO;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL accept_valid: got %b want 0", bus.out_valid); end
      checks++; if (bus.busy !== !expect_idle) begin errors++; $display("FAIL accept_busy: got %b want %b", bus.busy, !expect_idle); end
      checks++; if (bus.out_frame_id !== exp_fid) begin errors++; $display("FAIL accept_frame_id: got %0d want %0d", bus.out_frame_id, exp_fid); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      bus.src_valid    = 1'b1;
      bus.cnn_ready_in = 1'b1;
      #1;
      checks++; if ({bus.busy, bus.src_ready, bus.cnn_valid_in, bus.res_ready, bus.out_valid, bus.out_condition, bus.out_timeout} !== 7'b0) begin errors++; $display("FAIL reset_outputs: got %b want 0000000", {bus.busy, bus.src_ready, bus.cnn_valid_in, bus.res_ready, bus.out_valid, bus.out_condition, bus.out_timeout}); end
      checks++; if (bus.out_frame_id !== 8'd0) begin errors++; $display("FAIL reset_frame_id: got %0d want 0", bus.out_frame_id); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.src_ready !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy=%b src_ready=%b want 0 0", bus.busy, bus.src_ready); end
      bus.src_valid    = 1'b0;
      bus.cnn_ready_in = 1'b0;
   endtask

   task automatic test_basic();
      int cyc;
      feed(FL, 0, 1'b1, cyc);
      checks++; if (cyc !== FL) begin errors++; $display("FAIL basic_consecutive: got %0d cycles want %0d", cyc, FL); end
      give_result(32'h0100_0000, 32'h0080_0000, 1'b0);
      accept(1'b0);
      if (expect_idle) begin
         @(negedge clk);
         #1;
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_start: busy got %b want 0", bus.busy); end
      end
   endtask

   task automatic test_gaps();
      int cyc;
      feed(FL, 1, 1'b0, cyc);
      checks++; if (cyc !== 11) begin errors++; $display("FAIL gaps_cycles: got %0d want 11", cyc); end
      give_result(32'hFE00_0000, 32'hFF00_0000, 1'b1);
      accept(1'b0);
   endtask

   task automatic test_timeout();
      int cyc;
      int waited;
      feed(FL, 0, 1'b0, cyc);
      waited = 0;
      #1;
      while (!bus.out_valid && waited < 20) begin
         @(negedge clk);
         waited++;
         #1;
      end
      checks++; if (waited !== TO) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", waited, TO); end
      checks++; if (bus.out_timeout !== 1'b1 || bus.out_condition !== 1'b0) begin errors++; $display("FAIL timeout_flags: timeout=%b cond=%b want 1 0", bus.out_timeout, bus.out_condition); end
      checks++; if (bus.out_frame_id !== exp_fid) begin errors++; $display("FAIL timeout_frame_id: got %0d want %0d", bus.out_frame_id, exp_fid); end
      accept(1'b1);
   endtask

   task automatic test_expiry_race_and_hold();
      int cyc;
      feed(FL, 0, 1'b0, cyc);
      repeat (TO - 1) @(negedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL race_pre: out_valid got %b want 0", bus.out_valid); end
      give_result(32'h0000_0010, 32'h0000_0020, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checks++; if ({bus.out_valid, bus.out_condition, bus.out_timeout} !== 3'b110 || bus.out_frame_id !== exp_fid) begin errors++; $display("FAIL hold_stable: valid/cond/timeout=%b id=%0d want 110 id=%0d", {bus.out_valid, bus.out_condition, bus.out_timeout}, bus.out_frame_id, exp_fid); end
      end
      accept(1'b0);
   endtask

   task automatic test_midframe_reset();
      int cyc;
      feed(2, 0, 1'b0, cyc);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.src_valid    = 1'b1;
      bus.cnn_ready_in = 1'b1;
      exp_fid     = '0;
      expect_idle = 1'b1;
      #1;
      checks++; if ({bus.busy, bus.src_ready, bus.cnn_valid_in, bus.res_ready, bus.out_valid, bus.out_condition, bus.out_timeout} !== 7'b0) begin errors++; $display("FAIL midreset_outputs: got %b want 0000000", {bus.busy, bus.src_ready, bus.cnn_valid_in, bus.res_ready, bus.out_valid, bus.out_condition, bus.out_timeout}); end
      checks++; if (bus.out_frame_id !== 8'd0) begin errors++; $display("FAIL midreset_frame_id: got %0d want 0", bus.out_frame_id); end
      bus.src_valid    = 1'b0;
      bus.cnn_ready_in = 1'b0;
      @(negedge clk);
      feed(FL, 0, 1'b0, cyc);
      checks++; if (cyc !== FL) begin errors++; $display("FAIL midreset_refeed: got %0d cycles want %0d", cyc, FL); end
      give_result(32'h0000_0005, 32'h0000_0005, 1'b0);
      accept(1'b0);
   endtask

   task automatic test_back_to_back();
      int cyc;
      for (int f = 0; f < 2; f++) begin
         feed(FL, 0, 1'b0, cyc);
         give_result(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
         accept(1'b0);
      end
   endtask

   initial begin
      bus.start        = 1'b0;
      bus.src_valid    = 1'b0;
      bus.src_data     = '0;
      bus.cnn_ready_in = 1'b0;
      bus.res_valid    = 1'b0;
      bus.res_data0    = '0;
      bus.res_data1    = '0;
      bus.out_ready    = 1'b0;
      test_reset();
      test_basic();
      test_gaps();
      test_timeout();
      test_expiry_race_and_hold();
      test_midframe_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cnn1d_infer_ctrl.md
Name: cnn1d_infer_ctrl

Overview:
Frame-level sequencer for the 1D CNN inference datapath. It gates a raw sample stream into the conv input for exactly FRAME_LEN samples (one global-average-pool window) per inference. It then waits for the two neuron-layer scores, compares them, and reports a tagged NEW/WORN decision. A watchdog covers a stalled datapath.

Parameters:
DATA_WIDTH, 32, sample and score width (two's-complement fixed point)
FRAME_LEN, 256, samples per inference; must equal the pool layer POOL_SIZE; FRAME_LEN >= 1
TIMEOUT_CYCLES, 65535, max cycles in WAIT before abort; >= 1
FRAME_ID_WIDTH, 8, width of frame tag counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
start  in  1  begin one inference; sampled only in IDLE
busy  out  1  high in any state except IDLE
src_valid  in  1  upstream sample valid
src_ready  out  1  upstream sample ready
src_data  in  DATA_WIDTH  upstream sample
cnn_valid_in  out  1  to conv layer valid
cnn_ready_in  in  1  from conv layer ready
cnn_data_in  out  DATA_WIDTH  to conv layer data
res_valid  in  1  neuron layer outputs valid
res_ready  out  1  neuron layer output ready (drives cnn_ready_out)
res_data0  in  DATA_WIDTH  score, class NEW
res_data1  in  DATA_WIDTH  score, class WORN
out_valid  out  1  decision valid
out_ready  in  1  decision consumer ready
out_condition  out  1  0=NEW, 1=WORN
out_timeout  out  1  decision aborted by watchdog; out_condition forced 0
out_frame_id  out  FRAME_ID_WIDTH  tag of reported frame

Behaviour:
- FSM states: IDLE, FEED, WAIT, REPORT. On reset: state IDLE; sample count 0; timeout count 0; frame_id 0; all outputs 0.
- The reset values above also apply to src_ready, cnn_valid_in, res_ready, out_*, and busy.
- IDLE: src_ready=0, cnn_valid_in=0, res_ready=0. If start=1, go to FEED and clear the sample count. start in any other state is ignored (no queuing).
- FEED: zero-latency combinational pass-through.
  - cnn_valid_in = src_valid; src_ready = cnn_ready_in; cnn_data_in = src_data. cnn_data_in is always src_data.
  - A sample counts on src_valid & cnn_ready_in.
  - On the counted handshake with count == FRAME_LEN-1, go to WAIT and clear the timeout count.
  - res_ready=0 in FEED; a res_valid arriving in FEED is held off by the datapath.
- WAIT: src_ready=0, cnn_valid_in=0, res_ready=1. On res_valid, register out_condition = ($signed(res_data0) < $signed(res_data1)), set out_timeout=0, and go to REPORT.
  - A tie yields NEW (0).
  - Otherwise the timeout count increments each cycle. When it reaches TIMEOUT_CYCLES-1 with no res_valid, register out_condition=0 and out_timeout=1, then go to REPORT.
  - res_valid on the same cycle as expiry wins: normal result, out_timeout=0.
- REPORT: out_valid=1; out_condition, out_timeout, and out_frame_id are stable until accepted.
  - On out_ready: out_valid drops next cycle, frame_id increments (wraps modulo 2^FRAME_ID_WIDTH), go to IDLE.
- Latency: start to first cnn_valid_in is 1 cycle. Last input handshake to WAIT is 1 cycle. res_valid to out_valid is 1 cycle.
- rst asserted mid-frame returns to IDLE at once and clears frame_id. Partial-frame state inside the datapath is the datapath's own reset responsibility.

Optional Feature:
Macro CNN1D_INFER_CTRL_AUTORESTART_EN.
- Defined: on the REPORT accept, go directly to FEED (count cleared) instead of IDLE; start is then needed only once after reset or after a timeout report.
- A timeout report always returns to IDLE.
- Not defined: behaviour exactly as above; one start per frame.

Test Plan:
- FRAME_LEN=4, start pulse, src_valid=1, cnn_ready_in=1 throughout -> exactly 4 cnn handshakes on consecutive cycles, then src_ready=0; res_valid with data0=0x0100_0000, data1=0x0080_0000 -> out_valid next cycle, out_condition=0, out_frame_id=0.
- Same frame with cnn_ready_in toggling 1/0 and src_valid gaps -> still exactly 4 counted samples, no duplicates or drops; data1 > data0 (both negative, e.g. -2.0 vs -1.0) -> out_condition=1.
- TIMEOUT_CYCLES=8, frame fed, res_valid never asserted -> REPORT 8 cycles after entering WAIT, out_timeout=1, out_condition=0.
- res_valid on the expiry cycle -> out_timeout=0 and the compared result is reported.
- Hold out_ready=0 for 5 cycles in REPORT -> outputs stable. Raise out_ready -> frame_id increments to 1 and busy drops. A start pulse during FEED is ignored, with no second frame.
- rst pulsed after 2 of 4 samples -> all outputs 0 next cycle, frame_id=0. A new start feeds a full 4 samples.
- With CNN1D_INFER_CTRL_AUTORESTART_EN defined -> after the report is accepted, FEED resumes without start, frame_id increments per frame.
